// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of the single-port data memory
//
// Shares DataMemory between the core load/store path (cpu_*) and a DMA/debug
// port (dma_*). Each port uses a req/done handshake. Ties in IDLE are broken
// in favour of the port that was not served last.
//
// Ports:
//   clk, reset                : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata     : core access request, held until cpu_done
//   cpu_rdata, cpu_done       : registered load data, one-cycle completion pulse
//   cpu_stall                 : freezes the core PC while its access is pending
//   dma_req/we/addr/wdata     : DMA access request, held until dma_done
//   dma_rdata, dma_done       : registered load data, one-cycle completion pulse
//   dma_gnt                   : high while the DMA owns the memory
//   mem_addr/wdata/we/re      : DataMemory address, write data, MemWrite, MemRead
//   mem_rdata                 : DataMemory ReadData (combinational read)

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_done,
  output logic                  dma_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT_CPU = 3'd1,
    GRANT_DMA = 3'd2,
    RESP_CPU  = 3'd3,
    RESP_DMA  = 3'd4
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  state_t state;
  logic   lastOwner;
  logic   cpuWins;

  // CPU takes the slot when it is alone, or on a tie when the DMA went last.
  assign cpuWins = cpu_req && (!dma_req || (lastOwner == OWNER_DMA));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lastOwner <= OWNER_DMA;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpuWins) begin
            state     <= GRANT_CPU;
            lastOwner <= OWNER_CPU;
          end else if (dma_req) begin
            state     <= GRANT_DMA;
            lastOwner <= OWNER_DMA;
          end
        end
        GRANT_CPU: begin
          if (!cpu_we) cpu_rdata <= mem_rdata;
          state <= RESP_CPU;
        end
        GRANT_DMA: begin
          if (!dma_we) dma_rdata <= mem_rdata;
          state <= RESP_DMA;
        end
        RESP_CPU: state <= IDLE;
        RESP_DMA: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs are decoded from state; everything is forced idle
  // while reset is low so a GRANT caught by reset never writes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (reset) begin
      if (state == GRANT_CPU) begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = ~cpu_we;
      end else if (state == GRANT_DMA) begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
        mem_re    = ~dma_we;
      end
    end
  end

  assign cpu_done  = reset && (state == RESP_CPU);
  assign dma_done  = reset && (state == RESP_DMA);
  assign dma_gnt   = reset && (state == GRANT_DMA);
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule
